bram_fifo_ctrl: RTL and testbench

Single-clock FIFO controller wrapped around the dual-port block RAM core, which it drives with both ports on the same clock. Accepts a valid/ready write stream, stores words in the RAM, and handles the RAM's 1-cycle registered read latency through a 2-entry output skid buffer. Presents a show-ahead valid/ready read stream with full throughput. Sits between a producer stream and a consumer, with the RAM instantiated alongside it.

---
 rtl/bram_fifo_ctrl.sv | 145 ++++++++++++++
 tb/tb_bram_fifo_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller in front of a dual-port block RAM with 1-cycle read latency.
// A 2-entry skid buffer provides a show-ahead output. Optional level flags: BRAM_FIFO_LEVEL_FLAGS_EN.
module bram_fifo_ctrl #(
   parameter int ADDR_WIDTH    = 3,
   parameter int DATA_WIDTH    = 8,
   parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 2,
   parameter int AEMPTY_THRESH = 1
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  ram_wren,
   output logic [ADDR_WIDTH-1:0] ram_wraddr,
   output logic [DATA_WIDTH-1:0] ram_wrdata,
   output logic                  ram_rden,
   output logic [ADDR_WIDTH-1:0] ram_rdaddr,
   input  logic [DATA_WIDTH-1:0] ram_rddata,
   output logic [ADDR_WIDTH+1:0] level,
   output logic                  almost_full,
   output logic                  almost_empty
);

   localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

   logic                  active;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   ram_cnt;
   logic [ADDR_WIDTH:0]   ram_cnt_nxt;
   logic                  inflight;
   logic [1:0]            skid_cnt;
   logic [1:0]            skid_cnt_nxt;
   logic [DATA_WIDTH-1:0] skid0;
   logic [DATA_WIDTH-1:0] skid0_nxt;
   logic [DATA_WIDTH-1:0] skid1;
   logic [DATA_WIDTH-1:0] skid1_nxt;
   logic [2:0]            occ_after_pop;
   logic                  push;
   logic                  pop;

   // in_ready stays low while reset is held and for the first edge after release.
   assign in_ready   = active & (ram_cnt != DEPTH);
   assign push       = in_valid & in_ready;
   assign out_valid  = (skid_cnt != 2'd0);
   assign pop        = out_valid & out_ready;
   assign out_data   = skid0;

   assign ram_wren   = push;
   assign ram_wraddr = wr_ptr;
   assign ram_wrdata = in_data;

   // Prefetch only while the skid buffer plus the word in flight leaves room.
   assign occ_after_pop = {1'b0, skid_cnt} + {2'b00, inflight} - {2'b00, pop};
   assign ram_rden      = (ram_cnt != '0) & (occ_after_pop < 3'd2);
   assign ram_rdaddr    = rd_ptr;

   assign ram_cnt_nxt = ram_cnt + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(ram_rden);
   assign level       = (ADDR_WIDTH+2)'(ram_cnt) + (ADDR_WIDTH+2)'(inflight)
                      + (ADDR_WIDTH+2)'(skid_cnt);

   always_comb begin
      skid_cnt_nxt = skid_cnt;
      skid0_nxt    = skid0;
      skid1_nxt    = skid1;
      case (skid_cnt)
         2'd0: begin
            if (inflight) begin
               skid0_nxt    = ram_rddata;
               skid_cnt_nxt = 2'd1;
            end
         end
         2'd1: begin
            if (inflight && pop) begin
               skid0_nxt = ram_rddata;
            end else if (inflight) begin
               skid1_nxt    = ram_rddata;
               skid_cnt_nxt = 2'd2;
            end else if (pop) begin
               skid_cnt_nxt = 2'd0;
            end
         end
         default: begin
            if (pop) begin
               skid0_nxt = skid1;
               if (inflight) begin
                  skid1_nxt = ram_rddata;
               end else begin
                  skid_cnt_nxt = 2'd1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         active   <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ram_cnt  <= '0;
         inflight <= 1'b0;
         skid_cnt <= 2'd0;
         skid0    <= '0;
      end else begin
         active   <= 1'b1;
         if (push)     wr_ptr <= wr_ptr + 1'b1;
         if (ram_rden) rd_ptr <= rd_ptr + 1'b1;
         ram_cnt  <= ram_cnt_nxt;
         inflight <= ram_rden;
         skid_cnt <= skid_cnt_nxt;
         skid0    <= skid0_nxt;
      end
   end

   // Second skid slot is only ever read once skid_cnt says it is valid.
   always_ff @(posedge aclk) begin
      skid1 <= skid1_nxt;
   end

`ifdef BRAM_FIFO_LEVEL_FLAGS_EN
   logic [ADDR_WIDTH+1:0] level_nxt;

   assign level_nxt = (ADDR_WIDTH+2)'(ram_cnt_nxt) + (ADDR_WIDTH+2)'(ram_rden)
                    + (ADDR_WIDTH+2)'(skid_cnt_nxt);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         almost_full  <= (int'(level_nxt) >= AFULL_THRESH);
         almost_empty <= (int'(level_nxt) <= AEMPTY_THRESH);
      end
   end
`else
   assign almost_full  = 1'b0;
   assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl: behavioural RAM, queue-based reference model, directed and random traffic.
module tb_bram_fifo_ctrl;

   localparam int AW  = 3;
   localparam int DW  = 8;
   localparam int CAP = 2**AW + 2;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          ram_wren;
   logic [AW-1:0] ram_wraddr;
   logic [DW-1:0] ram_wrdata;
   logic          ram_rden;
   logic [AW-1:0] ram_rdaddr;
   logic [DW-1:0] ram_rddata = '0;
   logic [AW+1:0] level;
   logic          almost_full;
   logic          almost_empty;

   logic [DW-1:0] mem [2**AW];

   int            n_assert = 0;
   int            n_fail = 0;
   logic [DW-1:0] model_q [$];
   int            wr_count = 0;
   int            pops = 0;
   int            pushes = 0;

   bram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .ram_wren(ram_wren), .ram_wraddr(ram_wraddr), .ram_wrdata(ram_wrdata),
      .ram_rden(ram_rden), .ram_rdaddr(ram_rdaddr), .ram_rddata(ram_rddata),
      .level(level), .almost_full(almost_full), .almost_empty(almost_empty)
   );

   always #5 aclk = ~aclk;

   // Dual-port RAM with registered read.
   always @(posedge aclk) begin
      if (ram_wren) mem[ram_wraddr] <= ram_wrdata;
      if (ram_rden) ram_rddata <= mem[ram_rdaddr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called shortly after a rising edge with inputs driven; advances one clock.
   task automatic tick();
      logic push, pop;
      #2;
      push = in_valid & in_ready;
      pop  = out_valid & out_ready;
      chk("wren", ram_wren, push);
      if (push) chk("wraddr", ram_wraddr, wr_count % (2**AW));
      if (out_valid) chk("no_underflow", model_q.size() > 0, 1);
      if (pop && model_q.size() > 0) begin
         chk("out_data", out_data, model_q[0]);
         void'(model_q.pop_front());
         pops++;
      end
      if (push) begin
         model_q.push_back(in_data);
         wr_count++;
         pushes++;
      end
      @(posedge aclk);
      #1;
      chk("level", level, model_q.size());
      if (level > CAP) chk("level_bound", level, CAP);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (model_q.size() > 0 && n < budget) begin
         tick();
         n++;
      end
      if (model_q.size() > 0) chk("drain_timeout", model_q.size(), 0);
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_level", level, 0);
      chk("rst_wren", ram_wren, 0);
      chk("rst_rden", ram_rden, 0);
      chk("rst_afull", almost_full, 0);
      chk("rst_aempty", almost_empty, 0);
      @(posedge aclk); #1;
      aresetn = 1'b1;
      @(posedge aclk); #1;
      chk("in_ready_after_rst", in_ready, 1);

      // Single word latency
      in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("lat_rden_c1", ram_rden, 1);
      chk("lat_level_c1", level, 1);
      tick();
      chk("lat_valid_c2", out_valid, 0);
      tick();
      chk("lat_valid_c3", out_valid, 1);
      chk("lat_data_c3", out_data, 8'hA5);
      tick();
      chk("lat_empty", out_valid, 0);

      // Fill with consumer stalled
      out_ready = 1'b0;
      for (int i = 0; i < CAP; i++) begin
         in_valid = 1'b1; in_data = DW'(i);
         chk("fill_ready", in_ready, 1);
         tick();
      end
      chk("full_in_ready", in_ready, 0);
      chk("full_level", level, CAP);
      in_data = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("full_no_wren", ram_wren, 0);
      end

      // Drain with no bubbles
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < CAP; i++) begin
         chk("drain_valid", out_valid, 1);
         tick();
      end
      chk("drained_valid", out_valid, 0);
      chk("drained_level", level, 0);

      // Continuous streaming
      pops = 0;
      for (int k = 0; k < 46; k++) begin
         in_valid = (k < 40); in_data = DW'(k + 8'h40); out_ready = 1'b1;
         if (k >= 3 && k < 43) chk("stream_no_bubble", out_valid, 1);
         tick();
      end
      drain(20);
      chk("stream_count", pops, 40);

      // Random traffic
      pushes = 0; pops = 0;
      for (int c = 0; c < 20000 && pushes < 1000; c++) begin
         in_valid  = ($urandom_range(0, 1) == 1) && (pushes < 1000);
         in_data   = DW'($urandom);
         out_ready = ($urandom_range(0, 1) == 1);
         tick();
      end
      chk("rand_pushes", pushes, 1000);
      drain(100);
      chk("rand_pops", pops, 1000);

      // Reset with words held and a read in flight
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_data = DW'(8'h80 + i);
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("pre_rst_level", level, 5);
      #2;
      aresetn = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_level", level, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      model_q.delete();
      wr_count = 0;
      @(posedge aclk); #1;
      aresetn = 1'b1;
      @(posedge aclk); #1;
      chk("post_rst_ready", in_ready, 1);
      pops = 0;
      in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("post_rst_pops", pops, 1);
      chk("post_rst_level", level, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
